msg_key_assembler: RTL and testbench
====================================

Name: msg_key_assembler

Overview:
- Parametrised successor of the single-word message/key capture stage on the FPGA crypto path.
- Collects MSG_WORDS message words, then KEY_WORDS key words, from the FIFO read port, honouring a configurable FIFO read latency.
- Presents each assembled {msg, key} block to the cipher core over a valid/ready handshake.
- Double-buffered (assembly register + output register); exports rd_allow so the FIFO reader never overruns the block.

Parameters:
- DATA_W, 64, FIFO word width in bits.
- MSG_WORDS, 1, message words per block (>=1).
- KEY_WORDS, 1, key words per block (>=1).
- RD_LATENCY, 1, cycles from rd_en to valid data (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- data  in  DATA_W  FIFO read data
- rd_en  in  1  FIFO read strobe (data valid RD_LATENCY cycles later)
- rd_allow  out  1  upstream may issue rd_en this cycle
- msg  out  DATA_W*MSG_WORDS  assembled message
- key  out  DATA_W*KEY_WORDS  assembled key
- out_valid  out  1  msg/key hold a complete block
- out_ready  in  1  consumer accepts block
- overflow  out  1  sticky: word arrived with no free slot

Behaviour:
- Reset (async assert, sync release): latency pipe, word_cnt, both buffers, out_valid, overflow = 0; msg = key = 0; rd_allow = 1.
- Capture strobe cap = rd_en delayed RD_LATENCY cycles (shift register).
- On cap, data is written to assembly slot word_cnt. Slots 0..MSG_WORDS-1 are message; the rest are key. The first word lands in the most-significant slice of its field.
- word_cnt increments on cap and wraps to 0 after slot TOTAL-1 (TOTAL = MSG_WORDS+KEY_WORDS).
- Assembly FSM states:
  - FILL: capturing words.
  - FULL: block complete, waiting for output register.
- FILL->FULL on the last-slot cap when the output register is occupied and not being drained this cycle. Otherwise the block moves straight into the output register and the FSM stays in FILL.
- FULL->FILL when the output register frees (out_valid & out_ready). The block transfers that same cycle.
- Output: out_valid rises the cycle after the transfer into the output register. It is cleared on out_valid & out_ready unless a new block transfers in the same cycle, in which case it stays 1 with new contents.
- Output contents are stable while out_valid & !out_ready.
- rd_allow = inflight < capacity, where:
  - inflight = ones in the latency pipe;
  - capacity = (FULL ? 0 : TOTAL - word_cnt) + (out_valid ? 0 : TOTAL).
  - rd_allow is combinational from registers only.
- Overflow: a cap in FULL state drops the word, holds word_cnt, and sets overflow until rst.
- Reset mid-block discards partial data and in-flight reads.

Optional Feature:
- MSG_KEY_KEEP_EN defined:
  - Adds input key_keep (1 bit), sampled on the first cap of a block.
  - If high, only MSG_WORDS are captured. The previous key is retained and the block completes after slot MSG_WORDS-1. TOTAL in the capacity term uses MSG_WORDS for that block.
  - key reset value is 0, so key reuse before any key is loaded yields zeros.
- Undefined: no key_keep port; every block captures TOTAL words.

Decomposition:
- msg_key_pkg: TOTAL, CNT_W = $clog2(TOTAL), FSM state enum {FILL, FULL}.
- Sub-module rd_latency_pipe: RD_LATENCY-deep rd_en delay line with a popcount output (inflight).

Test Plan:
- Defaults, rd_en on 2 consecutive cycles with data A5A5..., 3C3C... -> 1 cycle after the second cap: out_valid=1, msg=A5A5..., key=3C3C...; out_ready=1 clears out_valid the next cycle.
- MSG_WORDS=2, KEY_WORDS=2, RD_LATENCY=3, words 1,2,3,4 -> msg={1,2}, key={3,4}; out_valid 4 cycles after the last rd_en.
- out_ready=0, upstream issues rd_en whenever rd_allow -> exactly 2 blocks buffered, rd_allow=0, overflow stays 0; pulse out_ready -> second block shifts in with out_valid held 1.
- Force rd_en high while rd_allow=0 with output full -> extra word dropped, overflow=1 sticky, msg/key unchanged.
- Assert rst after 1 of 2 words, then send 2 words B,C -> msg=B, key=C; no stale word.
- MSG_KEY_KEEP_EN: block 1 key=K1; block 2 with key_keep=1 and 1 word M2 -> msg=M2, key=K1, rd_allow permits only 1 word.

Source files
------------

// File: rtl/msg_key_pkg.sv
// rtl/msg_key_pkg.sv - shared types and sizing helpers for the message/key assembler
package msg_key_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } asm_state_e;

    function automatic int total_words(input int msg_words, input int key_words);
        return msg_words + key_words;
    endfunction

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// rtl/rd_latency_pipe.sv - rd_en delay line producing the capture strobe and in-flight read count
module rd_latency_pipe #(
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rd_en,
    output logic             o_cap,
    output logic [CNT_W-1:0] o_inflight
);

    logic [DEPTH-1:0] r_pipe;
    logic [CNT_W-1:0] w_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | DEPTH'(i_rd_en);
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CNT_W'(r_pipe[i]);
        end
    end

    assign o_cap      = r_pipe[DEPTH-1];
    assign o_inflight = w_count;

endmodule

// File: rtl/msg_key_assembler.sv
// rtl/msg_key_assembler.sv - double-buffered {msg, key} block assembler behind a FIFO read port
// Optional key reuse (key_keep input) is enabled by defining MSG_KEY_KEEP_EN.
module msg_key_assembler
    import msg_key_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int MSG_WORDS  = 1,
    parameter int KEY_WORDS  = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           data,
    input  logic                        rd_en,
    output logic                        rd_allow,
    output logic [DATA_W*MSG_WORDS-1:0] msg,
    output logic [DATA_W*KEY_WORDS-1:0] key,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow
`ifdef MSG_KEY_KEEP_EN
    ,
    input  logic                        key_keep
`endif
);

    localparam int TOTAL = total_words(MSG_WORDS, KEY_WORDS);
    localparam int CNT_W = cnt_width(TOTAL);
    localparam int INF_W = $clog2(RD_LATENCY + 1);

    asm_state_e                  r_state;
    asm_state_e                  w_state_nxt;
    logic [DATA_W-1:0]           r_asm [TOTAL];
    logic [CNT_W-1:0]            r_word_cnt;
    logic [DATA_W*MSG_WORDS-1:0] r_msg;
    logic [DATA_W*KEY_WORDS-1:0] r_key;
    logic                        r_out_valid;
    logic                        r_overflow;

    logic                        w_cap;
    logic [INF_W-1:0]            w_inflight;
    logic                        w_drain;
    logic                        w_accept;
    logic                        w_last;
    logic                        w_drop;
    logic                        w_load;
    logic [CNT_W-1:0]            w_last_idx;
    logic [DATA_W-1:0]           w_blk [TOTAL];
    logic [DATA_W*MSG_WORDS-1:0] w_blk_msg;
    logic [DATA_W*KEY_WORDS-1:0] w_blk_key;
    int                          w_blk_total;
    int                          w_capacity;

`ifdef MSG_KEY_KEEP_EN
    logic r_keep;
    logic w_keep_blk;
`endif

    rd_latency_pipe #(
        .DEPTH (RD_LATENCY),
        .CNT_W (INF_W)
    ) u_rd_latency_pipe (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_en    (rd_en),
        .o_cap      (w_cap),
        .o_inflight (w_inflight)
    );

    assign w_drain = r_out_valid & out_ready;

    // Key-reuse blocks end after the message slots; the key slots keep the last loaded key.
`ifdef MSG_KEY_KEEP_EN
    assign w_keep_blk = (r_word_cnt == '0) ? key_keep : r_keep;
    assign w_last_idx = w_keep_blk ? CNT_W'(MSG_WORDS - 1) : CNT_W'(TOTAL - 1);
`else
    assign w_last_idx = CNT_W'(TOTAL - 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_last && r_out_valid && !out_ready) w_state_nxt = FULL;
            FULL:    if (w_drain) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_comb begin
        w_accept = w_cap && (r_state == FILL);
        w_last   = w_accept && (r_word_cnt == w_last_idx);
        w_drop   = w_cap && (r_state == FULL);
        w_load   = (w_last && !(r_out_valid && !out_ready)) || ((r_state == FULL) && w_drain);
    end

    // The block being completed this cycle bypasses the assembly register into the output.
    always_comb begin
        for (int i = 0; i < TOTAL; i++) begin
            w_blk[i] = (w_accept && (r_word_cnt == CNT_W'(i))) ? data : r_asm[i];
        end
        w_blk_msg = '0;
        w_blk_key = '0;
        for (int i = 0; i < MSG_WORDS; i++) begin
            w_blk_msg[(MSG_WORDS-1-i)*DATA_W +: DATA_W] = w_blk[i];
        end
        for (int j = 0; j < KEY_WORDS; j++) begin
            w_blk_key[(KEY_WORDS-1-j)*DATA_W +: DATA_W] = w_blk[MSG_WORDS+j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TOTAL; i++) begin
                r_asm[i] <= '0;
            end
            r_word_cnt  <= '0;
            r_msg       <= '0;
            r_key       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < TOTAL; i++) begin
                    if (r_word_cnt == CNT_W'(i)) r_asm[i] <= data;
                end
                r_word_cnt <= w_last ? '0 : r_word_cnt + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                r_msg       <= w_blk_msg;
                r_key       <= w_blk_key;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MSG_KEY_KEEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keep <= 1'b0;
        end else if (w_accept && (r_word_cnt == '0)) begin
            r_keep <= key_keep;
        end
    end
`endif

    // Free slots = remainder of the assembly register plus an empty output register.
    always_comb begin
        w_blk_total = TOTAL;
`ifdef MSG_KEY_KEEP_EN
        if (r_keep && (r_word_cnt != '0)) w_blk_total = MSG_WORDS;
`endif
        w_capacity = ((r_state == FULL) ? 0 : (w_blk_total - int'(r_word_cnt)))
                   + (r_out_valid ? 0 : TOTAL);
    end

    assign rd_allow  = int'(w_inflight) < w_capacity;
    assign msg       = r_msg;
    assign key       = r_key;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_msg_key_assembler.sv
// tb/tb_msg_key_assembler.sv - directed self-checking bench for msg_key_assembler
module tb_msg_key_assembler;

    logic         clk = 1'b0;
    logic         rst;
    int           errors = 0;
    int           checks = 0;

    logic [63:0]  data0;
    logic         rd_en0, rd_allow0, out_valid0, out_ready0, overflow0, key_keep0;
    logic [63:0]  msg0, key0;
    logic [63:0]  mem0 [16];
    int           ptr0 = 0;

    logic [63:0]  data1;
    logic         rd_en1, rd_allow1, out_valid1, out_ready1, overflow1;
    logic [127:0] msg1, key1;
    logic [63:0]  mem1 [8];
    logic [63:0]  d1 [3];
    int           ptr1 = 0;

    always #5 clk = ~clk;

    msg_key_assembler dut0 (
        .clk       (clk),
        .rst       (rst),
        .data      (data0),
        .rd_en     (rd_en0),
        .rd_allow  (rd_allow0),
        .msg       (msg0),
        .key       (key0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .overflow  (overflow0)
`ifdef MSG_KEY_KEEP_EN
        ,
        .key_keep  (key_keep0)
`endif
    );

    msg_key_assembler #(
        .DATA_W     (64),
        .MSG_WORDS  (2),
        .KEY_WORDS  (2),
        .RD_LATENCY (3)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .data      (data1),
        .rd_en     (rd_en1),
        .rd_allow  (rd_allow1),
        .msg       (msg1),
        .key       (key1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .overflow  (overflow1)
`ifdef MSG_KEY_KEEP_EN
        ,
        .key_keep  (1'b0)
`endif
    );

    always @(posedge clk) begin
        if (rd_en0) begin
            data0 <= mem0[ptr0];
            ptr0  <= ptr0 + 1;
        end
    end

    always @(posedge clk) begin
        d1[0] <= rd_en1 ? mem1[ptr1] : 64'h0;
        d1[1] <= d1[0];
        d1[2] <= d1[1];
        if (rd_en1) ptr1 <= ptr1 + 1;
    end
    assign data1 = d1[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid0); end
        checks++; if (rd_allow0 !== 1'b1) begin errors++; $display("FAIL reset_rd_allow: got %b expected 1", rd_allow0); end
        checks++; if (msg0 !== 64'h0) begin errors++; $display("FAIL reset_msg: got %h expected 0", msg0); end
        checks++; if (key0 !== 64'h0) begin errors++; $display("FAIL reset_key: got %h expected 0", key0); end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow0); end
        checks++; if (rd_allow1 !== 1'b1) begin errors++; $display("FAIL reset_rd_allow1: got %b expected 1", rd_allow1); end
    endtask

    task automatic test_single_block();
        rd_en0 = 1'b1;
        tick();
        tick();
        rd_en0 = 1'b0;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", out_valid0); end
        tick();
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid0); end
        checks++; if (msg0 !== 64'hA5A5A5A5A5A5A5A5) begin errors++; $display("FAIL single_msg: got %h expected a5a5a5a5a5a5a5a5", msg0); end
        checks++; if (key0 !== 64'h3C3C3C3C3C3C3C3C) begin errors++; $display("FAIL single_key: got %h expected 3c3c3c3c3c3c3c3c", key0); end
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_consume: got %b expected 0", out_valid0); end
    endtask

    task automatic test_multi_word();
        rd_en1 = 1'b1;
        repeat (4) tick();
        rd_en1 = 1'b0;
        tick();
        tick();
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL multi_early_valid: got %b expected 0", out_valid1); end
        tick();
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL multi_valid: got %b expected 1", out_valid1); end
        checks++; if (msg1 !== {64'd1, 64'd2}) begin errors++; $display("FAIL multi_msg: got %h expected %h", msg1, {64'd1, 64'd2}); end
        checks++; if (key1 !== {64'd3, 64'd4}) begin errors++; $display("FAIL multi_key: got %h expected %h", key1, {64'd3, 64'd4}); end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL multi_consume: got %b expected 0", out_valid1); end
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        for (int i = 0; i < 12; i++) begin
            rd_en0 = rd_allow0;
            if (rd_allow0) issued++;
            tick();
        end
        rd_en0 = 1'b0;
        tick();
        checks++; if (issued !== 4) begin errors++; $display("FAIL b2b_reads: got %0d expected 4", issued); end
        checks++; if (rd_allow0 !== 1'b0) begin errors++; $display("FAIL b2b_rd_allow: got %b expected 0", rd_allow0); end
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow0); end
        checks++; if (msg0 !== 64'h1111111111111111) begin errors++; $display("FAIL b2b_msg1: got %h expected 1111111111111111", msg0); end
        checks++; if (key0 !== 64'h2222222222222222) begin errors++; $display("FAIL b2b_key1: got %h expected 2222222222222222", key0); end
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL b2b_valid_held: got %b expected 1", out_valid0); end
        checks++; if (msg0 !== 64'h3333333333333333) begin errors++; $display("FAIL b2b_msg2: got %h expected 3333333333333333", msg0); end
        checks++; if (key0 !== 64'h4444444444444444) begin errors++; $display("FAIL b2b_key2: got %h expected 4444444444444444", key0); end
        checks++; if (rd_allow0 !== 1'b1) begin errors++; $display("FAIL b2b_rd_allow_free: got %b expected 1", rd_allow0); end
    endtask

    task automatic test_overflow();
        rd_en0 = 1'b1;
        tick();
        tick();
        rd_en0 = 1'b0;
        tick();
        checks++; if (rd_allow0 !== 1'b0) begin errors++; $display("FAIL ovf_rd_allow: got %b expected 0", rd_allow0); end
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        tick();
        checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow0); end
        checks++; if (msg0 !== 64'h3333333333333333) begin errors++; $display("FAIL ovf_msg_stable: got %h expected 3333333333333333", msg0); end
        checks++; if (key0 !== 64'h4444444444444444) begin errors++; $display("FAIL ovf_key_stable: got %h expected 4444444444444444", key0); end
        out_ready0 = 1'b1;
        tick();
        checks++; if (msg0 !== 64'h5555555555555555) begin errors++; $display("FAIL ovf_msg_next: got %h expected 5555555555555555", msg0); end
        checks++; if (key0 !== 64'h6666666666666666) begin errors++; $display("FAIL ovf_key_next: got %h expected 6666666666666666", key0); end
        tick();
        out_ready0 = 1'b0;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", out_valid0); end
        checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow0); end
    endtask

    task automatic test_reset_mid_block();
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow0); end
        checks++; if (rd_allow0 !== 1'b1) begin errors++; $display("FAIL rst_rd_allow: got %b expected 1", rd_allow0); end
        rst = 1'b0;
        rd_en0 = 1'b1;
        tick();
        tick();
        rd_en0 = 1'b0;
        tick();
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL rst_valid: got %b expected 1", out_valid0); end
        checks++; if (msg0 !== 64'hBBBBBBBBBBBBBBBB) begin errors++; $display("FAIL rst_msg: got %h expected bbbbbbbbbbbbbbbb", msg0); end
        checks++; if (key0 !== 64'hCCCCCCCCCCCCCCCC) begin errors++; $display("FAIL rst_key: got %h expected cccccccccccccccc", key0); end
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
    endtask

`ifdef MSG_KEY_KEEP_EN
    task automatic test_key_keep();
        key_keep0 = 1'b0;
        rd_en0 = 1'b1;
        tick();
        tick();
        rd_en0 = 1'b0;
        tick();
        checks++; if (key0 !== 64'hD1D1D1D1D1D1D1D1) begin errors++; $display("FAIL keep_key1: got %h expected d1d1d1d1d1d1d1d1", key0); end
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        key_keep0 = 1'b1;
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        tick();
        key_keep0 = 1'b0;
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL keep_valid: got %b expected 1", out_valid0); end
        checks++; if (msg0 !== 64'hE2E2E2E2E2E2E2E2) begin errors++; $display("FAIL keep_msg2: got %h expected e2e2e2e2e2e2e2e2", msg0); end
        checks++; if (key0 !== 64'hD1D1D1D1D1D1D1D1) begin errors++; $display("FAIL keep_key_reused: got %h expected d1d1d1d1d1d1d1d1", key0); end
    endtask
`endif

    initial begin
        mem0[0]  = 64'hA5A5A5A5A5A5A5A5;
        mem0[1]  = 64'h3C3C3C3C3C3C3C3C;
        mem0[2]  = 64'h1111111111111111;
        mem0[3]  = 64'h2222222222222222;
        mem0[4]  = 64'h3333333333333333;
        mem0[5]  = 64'h4444444444444444;
        mem0[6]  = 64'h5555555555555555;
        mem0[7]  = 64'h6666666666666666;
        mem0[8]  = 64'hDEADDEADDEADDEAD;
        mem0[9]  = 64'h7777777777777777;
        mem0[10] = 64'hBBBBBBBBBBBBBBBB;
        mem0[11] = 64'hCCCCCCCCCCCCCCCC;
        mem0[12] = 64'hC1C1C1C1C1C1C1C1;
        mem0[13] = 64'hD1D1D1D1D1D1D1D1;
        mem0[14] = 64'hE2E2E2E2E2E2E2E2;
        mem0[15] = 64'h0;
        for (int i = 0; i < 8; i++) mem1[i] = 64'(i + 1);
        rd_en0 = 1'b0;
        rd_en1 = 1'b0;
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        key_keep0 = 1'b0;
        data0 = 64'h0;
        d1[0] = 64'h0;
        d1[1] = 64'h0;
        d1[2] = 64'h0;
        rst = 1'b1;
        #1;
        test_reset();
        test_single_block();
        test_multi_word();
        test_back_to_back();
        test_overflow();
        test_reset_mid_block();
`ifdef MSG_KEY_KEEP_EN
        test_key_keep();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
